// File: rtl/fifo_reader.sv
// fifo_reader: pulls words from a standard-mode (1-cycle read latency) FIFO into a
// 2-entry output buffer and presents them as a valid/ready stream.
//
// Ports:
//   clk         single clock, rising edge
//   rst         asynchronous active-high reset
//   fifo_dout   FIFO read data, valid one cycle after fifo_rd_en
//   fifo_empty  FIFO empty flag
//   fifo_rd_en  FIFO read strobe (combinational)
//   out_data    oldest buffered word (0 when out_valid is low)
//   out_valid   out_data holds a valid word
//   out_ready   consumer accepts the word this cycle
//   word_count  (only with FIFO_READER_COUNT_EN) 16-bit wrapping count of accepted words
//
// Optional feature macro: FIFO_READER_COUNT_EN
module fifo_reader #(
  parameter int unsigned WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef FIFO_READER_COUNT_EN
  ,
  output logic [15:0]      word_count
`endif
);

  typedef enum logic [1:0] {
    OccEmpty = 2'd0,
    OccOne   = 2'd1,
    OccTwo   = 2'd2
  } occ_e;

  occ_e             occ_q, occ_d;
  logic             inflight_q;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             pop;
  logic [1:0]       level;

  assign out_valid = (occ_q != OccEmpty);
  assign out_data  = out_valid ? head_q : '0;
  assign pop       = out_valid && out_ready;

  // Occupancy after this edge, counting the word already in flight. occ+inflight never
  // exceeds 2 and pop implies occ>0, so this never goes negative.
  assign level = 2'(occ_q) + {1'b0, inflight_q} - {1'b0, pop};

  // Read only if the returning word is guaranteed a free slot.
  assign fifo_rd_en = !rst && !fifo_empty && (level < 2'd2);

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({inflight_q, pop})
      2'b10: begin
        // Capture only: fill the first free slot.
        if (occ_q == OccEmpty) begin
          head_d = fifo_dout;
          occ_d  = OccOne;
        end else begin
          tail_d = fifo_dout;
          occ_d  = OccTwo;
        end
      end
      2'b01: begin
        // Pop only: shift tail into head.
        head_d = tail_q;
        occ_d  = (occ_q == OccTwo) ? OccOne : OccEmpty;
      end
      2'b11: begin
        // Capture and pop together: occupancy unchanged, order preserved.
        if (occ_q == OccOne) begin
          head_d = fifo_dout;
        end else begin
          head_d = tail_q;
          tail_d = fifo_dout;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q      <= OccEmpty;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= fifo_rd_en;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

`ifdef FIFO_READER_COUNT_EN
  logic [15:0] count_q, count_d;

  assign count_d    = pop ? count_q + 16'd1 : count_q;
  assign word_count = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based behavioural model.
module tb_fifo_reader;
  localparam int W = 18;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] fifo_dout = '0;
  logic         fifo_empty = 1'b1;
  logic         fifo_rd_en;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
`ifdef FIFO_READER_COUNT_EN
  logic [15:0]  word_count;
`endif

  fifo_reader #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef FIFO_READER_COUNT_EN
    ,
    .word_count (word_count)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FIFO environment contents (driven by DUT reads) and the model's own copy.
  logic [W-1:0] fq[$];
  logic [W-1:0] mfifo[$];
  // Model: words held by the reader in delivery order, plus one word in flight.
  logic [W-1:0] mq[$];
  bit           m_infl = 1'b0;
  logic [W-1:0] m_word = '0;
  logic [15:0]  mcount = '0;
  int           m_pop, m_rd;

  task automatic push(input logic [W-1:0] w);
    fq.push_back(w);
    mfifo.push_back(w);
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic flush_fifo();
    fq.delete();
    mfifo.delete();
    fifo_empty = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Model update and FIFO environment, on the active edge.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_infl = 1'b0;
      mcount = '0;
    end else begin
      m_pop = (mq.size() > 0 && out_ready) ? 1 : 0;
      m_rd  = (mfifo.size() > 0 && (mq.size() + int'(m_infl) - m_pop) < 2) ? 1 : 0;
      if (m_pop != 0) begin
        void'(mq.pop_front());
        mcount = mcount + 16'd1;
      end
      if (m_infl) mq.push_back(m_word);
      m_infl = (m_rd != 0);
      if (m_rd != 0) m_word = mfifo.pop_front();
    end
    if (fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
    else fifo_dout <= W'($urandom);
  end

  always @(posedge clk) begin
    #1;
    fifo_empty = (fq.size() == 0);
  end

  // Compare process, away from the active edge.
  int c_pop;
  always @(negedge clk) begin
    if (rst) begin
      check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
    end else begin
      c_pop = (mq.size() > 0 && out_ready) ? 1 : 0;
      check("rd_en", 32'(fifo_rd_en),
            32'(!fifo_empty && (mq.size() + int'(m_infl) - c_pop) < 2));
      check("valid", 32'(out_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) check("data", 32'(out_data), 32'(mq[0]));
    end
`ifdef FIFO_READER_COUNT_EN
    check("word_count", 32'(word_count), rst ? 32'd0 : 32'(mcount));
`endif
  end

  logic         rd_s[8];
  logic         v_s[8];
  logic [W-1:0] d_s[8];
  logic [W-1:0] got[$];
  int           nrd, nv, rst_hold;
  bit           reached;

  initial begin
    // Reset with a word waiting: nothing may be read.
    #1 rst = 1'b1;
    step(1);
    push(18'h2AAAA);
    @(negedge clk);
    check("r_rd_en", 32'(fifo_rd_en), 32'd0);
    check("r_valid", 32'(out_valid), 32'd0);
    check("r_data", 32'(out_data), 32'd0);
    step(1);
    rst = 1'b0;
    @(negedge clk);
    check("r_first_rd", 32'(fifo_rd_en), 32'd1);
    step(1);
    out_ready = 1'b1;
    step(6);

    // Streaming 1..4.
    push(1); push(2); push(3); push(4);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rd_s[i] = fifo_rd_en;
      v_s[i]  = out_valid;
      d_s[i]  = out_data;
    end
    step(1);
    check("s_rd0", 32'(rd_s[0]), 32'd1);
    check("s_v1", 32'(v_s[1]), 32'd0);
    for (int i = 2; i < 6; i++) begin
      check("s_valid", 32'(v_s[i]), 32'd1);
      check("s_data", 32'(d_s[i]), 32'(i - 1));
    end
    check("s_v6", 32'(v_s[6]), 32'd0);

    // Backpressure with 5,6,7.
    out_ready = 1'b0;
    push(5); push(6); push(7);
    nrd = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      nrd += int'(fifo_rd_en);
      d_s[i] = out_data;
    end
    step(1);
    check("bp_reads", 32'(nrd), 32'd2);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_hold", 32'(d_s[3]), 32'd5);
    check("bp_hold_end", 32'(d_s[7]), 32'd5);
    out_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) got.push_back(out_data);
    end
    step(1);
    check("bp_count", 32'(got.size()), 32'd3);
    for (int i = 0; i < 3 && i < got.size(); i++) check("bp_order", 32'(got[i]), 32'(5 + i));

    // Empty boundary, then a single word 9.
    nrd = 0; nv = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      nrd += int'(fifo_rd_en);
      nv  += int'(out_valid);
    end
    step(1);
    check("e_rd", 32'(nrd), 32'd0);
    check("e_valid", 32'(nv), 32'd0);
    push(9);
    nrd = 0;
    got.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      nrd += int'(fifo_rd_en);
      if (out_valid) got.push_back(out_data);
    end
    step(1);
    check("e_pulse", 32'(nrd), 32'd1);
    check("e_count", 32'(got.size()), 32'd1);
    if (got.size() > 0) check("e_data", 32'(got[0]), 32'd9);

    // Reset with one word buffered and one in flight; the third is flushed upstream.
    out_ready = 1'b0;
    push(10); push(11); push(12);
    repeat (2) @(negedge clk);
    step(1);
    rst = 1'b1;
    flush_fifo();
    @(negedge clk);
    check("mr_valid", 32'(out_valid), 32'd0);
    check("mr_data", 32'(out_data), 32'd0);
    step(1);
    rst = 1'b0;
    out_ready = 1'b1;
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      nv += int'(out_valid);
    end
    step(1);
    check("mr_never_out", 32'(nv), 32'd0);
`ifdef FIFO_READER_COUNT_EN
    check("mr_count", 32'(word_count), 32'd0);

    // Counter: 3 words, then run up to 0xFFFF and wrap to 0x0001.
    push(20); push(21); push(22);
    step(8);
    check("cnt_3", 32'(word_count), 32'd3);
    for (int i = 0; i < 65532; i++) push(W'(i));
    reached = 1'b0;
    for (int i = 0; i < 70000 && !reached; i++) begin
      step(1);
      reached = (mcount == 16'hFFFF);
    end
    check("cnt_reach", 32'(reached), 32'd1);
    check("cnt_ffff", 32'(word_count), 32'hFFFF);
    push(1); push(2);
    step(8);
    check("cnt_wrap", 32'(word_count), 32'h0001);
`endif

    // Randomized traffic with occasional resets.
    rst_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      step(1);
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        rst_hold = $urandom_range(1, 2);
      end
      if (((c / 500) % 2) != 0) out_ready = ($urandom_range(0, 3) != 0);
      else out_ready = ($urandom_range(0, 1) != 0);
      if (fq.size() < 4 && $urandom_range(0, 2) != 0) push(W'($urandom));
    end
    rst = 1'b0;
    out_ready = 1'b1;
    step(12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
